posit_comp_arb: RTL
===================

# posit_comp_arb

Round-robin arbiter and two-stage pipeline controller that shares one lane-configurable posit two's-complement (absolute-value) unit among NREQ requesters. Each requester submits a 32-bit word and a lane mode: 4x8, 2x16 or 1x32. The block registers the granted operand, drives the shared combinational unit, captures its result and returns it with the requester ID under valid/ready backpressure. It sits between the FMA operand-extraction stages and the single complement datapath instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, width of requester ID; must be at least clog2(NREQ)
- CNTW, 16, width of saturating completed-operation counter
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous and active-high
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept (one-hot or zero)
- req_data  in  NREQ*32  operand words; requester i occupies bits [32i+31:32i]
- req_mode  in  NREQ*2  lane modes; requester i occupies bits [2i+1:2i]
- comp_in  out  32  operand to shared complement unit (stage-1 register)
- comp_mode  out  2  mode to shared unit (stage-1 register, normalised)
- comp_out  in  32  combinational result from shared unit
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  32  result word
- rsp_mode  out  2  mode of result (normalised)
- rsp_id  out  IDW  index of originating requester
- done_cnt  out  CNTW  completed responses, saturating

## Operation
- Mode encoding: 2'b00 = four 8-bit lanes; 2'b01 = two 16-bit lanes; 2'b1x = one 32-bit lane.
- Mode normalisation: 2'b11 is stored as 2'b10 at acceptance.
- Expected unit behaviour per lane: negate if lane MSB is set, else pass. The most negative lane value maps to itself.
- Stage 1 (S1) registers: s1_v, operand, mode, id. comp_in and comp_mode come directly from these registers.
- Stage 2 (S2) registers: s2_v, data, mode, id. rsp_* come directly from these registers.
- adv2 = s1_v & (!s2_v | rsp_ready). S2 loads comp_out, mode and id from S1.
- S2 clears when rsp_ready is high and no adv2 occurs.
- can_load = !s1_v | adv2. S1 loads the granted request. If adv2 occurs with no grant, s1_v clears.
- Arbitration: round-robin.
  - ptr holds the index of the last accepted requester.
  - Search order is ptr+1, ptr+2, …, wrapping modulo NREQ.
  - The first requester with req_valid set is granted.
- req_ready[i] = can_load & grant[i]. req_ready may depend combinationally on req_valid. At most one bit is high.
- ptr updates only on an accepted handshake. If no request is accepted, ptr holds.
- Requesters must hold data and mode stable while valid and not ready. Dropping valid before acceptance is permitted.
- done_cnt increments on each rsp_valid & rsp_ready and saturates at all-ones.
- Asynchronous reset mid-operation discards S1 and S2 contents without issuing a response. Operands in flight are lost, and requesters must re-issue.

## Timing
- Reset values:
  - s1_v, s2_v, rsp_valid = 0
  - comp_in, comp_mode, rsp_data, rsp_mode, rsp_id = 0
  - req_ready = 0
  - done_cnt = 0
  - ptr = NREQ-1, so requester 0 has first priority
- Latency: a request accepted at edge N appears on comp_in during cycle N+1. rsp_valid is high from N+2 (two-cycle latency).
- Throughput: one operation per cycle when rsp_ready is held high.
- Backpressure: with rsp_ready low, both S1 and S2 fill after 2 accepts, then req_ready = 0. When rsp_ready rises, S2 drains and S1 advances in the same cycle, and a new accept is possible in that same cycle.
- Simultaneous S2 drain and refill: rsp_valid stays high continuously; no bubble is inserted.
- rsp_data, rsp_mode and rsp_id stay stable while rsp_valid is high and rsp_ready is low.

## Test plan
- Reset then idle: all outputs 0, ptr = NREQ-1. A single req 0 with data 0x807FFF01, mode 00 → rsp_valid at +2 cycles, rsp_data = 0x807F0101, rsp_id = 0, done_cnt = 1.
- Mode coverage:
  - 0xFFFF0001, mode 01 → 0x00010001
  - 0xFFFFFFFE, mode 10 → 0x00000002
  - 0xFFFFFFFE, mode 11 → 0x00000002 with rsp_mode = 10
- Fairness: all four requesters valid continuously with rsp_ready = 1 → grants in order 0,1,2,3,0,…, one rsp per cycle, no requester starved.
- Backpressure: rsp_ready = 0 for 5 cycles with req 1 valid → exactly 2 accepts, then req_ready = 0 and rsp_* held stable. Raising rsp_ready gives in-order results with no loss or duplication.
- Reset mid-flight: assert rst with S1 and S2 full → rsp_valid drops immediately and done_cnt = 0. After release, first grant goes to requester 0.
- Counter saturation: with CNTW = 4, issue 20 responses → done_cnt sticks at 15.

Source files
------------

// File: rtl/posit_comp_arb_if.sv
// posit_comp_arb_if
// Groups the requester, shared-unit and response signals of posit_comp_arb.
//   req_valid/req_ready/req_data/req_mode : NREQ requesters (32-bit word + 2-bit mode each)
//   comp_in/comp_mode/comp_out            : shared combinational complement unit
//   rsp_valid/rsp_ready/rsp_data/rsp_mode/rsp_id : result stream
// Handshake rule for every valid/ready pair: a transfer happens on a rising
// clk edge where valid and ready are both high; the producer holds its payload
// stable while valid is high and ready is low (a requester may drop valid
// before acceptance). ready may depend combinationally on valid.
// slave modport: the arbiter. master modport: requesters, unit and consumer.
interface posit_comp_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_data;
  logic [NREQ*2-1:0]  req_mode;
  logic [31:0]        comp_in;
  logic [1:0]         comp_mode;
  logic [31:0]        comp_out;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_data;
  logic [1:0]         rsp_mode;
  logic [IDW-1:0]     rsp_id;

  modport slave (
    input  req_valid, req_data, req_mode, comp_out, rsp_ready,
    output req_ready, comp_in, comp_mode, rsp_valid, rsp_data, rsp_mode, rsp_id
  );

  modport master (
    output req_valid, req_data, req_mode, comp_out, rsp_ready,
    input  req_ready, comp_in, comp_mode, rsp_valid, rsp_data, rsp_mode, rsp_id
  );
endinterface

// File: rtl/posit_comp_arb.sv
// posit_comp_arb
// Round-robin arbiter and two-stage pipeline that shares one lane-configurable
// posit two's-complement unit among NREQ requesters.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : posit_comp_arb_if.slave (requests, shared unit, responses)
//   done_cnt  : saturating count of completed responses
//   dbg_ptr   : round-robin pointer (index of last accepted requester)
// Stage 1 holds the granted operand and drives the shared unit; stage 2
// captures the unit result and presents it on the response port.
module posit_comp_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic              clk,
  input  logic              rst,
  posit_comp_arb_if.slave   bus,
  output logic [CNTW-1:0]   done_cnt,
  output logic [IDW-1:0]    dbg_ptr
);

  logic            s1_v_q, s1_v_d;
  logic [31:0]     s1_data_q, s1_data_d;
  logic [1:0]      s1_mode_q, s1_mode_d;
  logic [IDW-1:0]  s1_id_q, s1_id_d;
  logic            s2_v_q, s2_v_d;
  logic [31:0]     s2_data_q, s2_data_d;
  logic [1:0]      s2_mode_q, s2_mode_d;
  logic [IDW-1:0]  s2_id_q, s2_id_d;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic            adv2;
  logic            can_load;
  logic            gnt_found;
  int              gnt_int;
  logic            accept;
  logic [1:0]      raw_mode;

  always_comb begin
    adv2     = s1_v_q & (~s2_v_q | bus.rsp_ready);
    can_load = ~s1_v_q | adv2;

    // Search ptr+1, ptr+2, ... modulo NREQ; first valid requester wins.
    gnt_found = 1'b0;
    gnt_int   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_found && bus.req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_int   = idx;
      end
    end

    accept        = can_load & gnt_found;
    bus.req_ready = '0;
    if (accept) bus.req_ready[gnt_int] = 1'b1;

    raw_mode = bus.req_mode[gnt_int*2 +: 2];

    s1_v_d    = s1_v_q;
    s1_data_d = s1_data_q;
    s1_mode_d = s1_mode_q;
    s1_id_d   = s1_id_q;
    if (accept) begin
      s1_v_d    = 1'b1;
      s1_data_d = bus.req_data[gnt_int*32 +: 32];
      // 2'b11 and 2'b10 both mean one 32-bit lane; keep a single encoding.
      s1_mode_d = raw_mode[1] ? 2'b10 : raw_mode;
      s1_id_d   = IDW'(gnt_int);
    end else if (adv2) begin
      s1_v_d = 1'b0;
    end

    s2_v_d    = s2_v_q;
    s2_data_d = s2_data_q;
    s2_mode_d = s2_mode_q;
    s2_id_d   = s2_id_q;
    if (adv2) begin
      s2_v_d    = 1'b1;
      s2_data_d = bus.comp_out;
      s2_mode_d = s1_mode_q;
      s2_id_d   = s1_id_q;
    end else if (bus.rsp_ready) begin
      s2_v_d = 1'b0;
    end

    ptr_d = accept ? IDW'(gnt_int) : ptr_q;

    cnt_d = cnt_q;
    if (s2_v_q && bus.rsp_ready && (cnt_q != {CNTW{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s1_mode_q <= '0;
      s1_id_q   <= '0;
      s2_v_q    <= 1'b0;
      s2_data_q <= '0;
      s2_mode_q <= '0;
      s2_id_q   <= '0;
      ptr_q     <= IDW'(NREQ - 1);
      cnt_q     <= '0;
    end else begin
      s1_v_q    <= s1_v_d;
      s1_data_q <= s1_data_d;
      s1_mode_q <= s1_mode_d;
      s1_id_q   <= s1_id_d;
      s2_v_q    <= s2_v_d;
      s2_data_q <= s2_data_d;
      s2_mode_q <= s2_mode_d;
      s2_id_q   <= s2_id_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.comp_in   = s1_data_q;
  assign bus.comp_mode = s1_mode_q;
  assign bus.rsp_valid = s2_v_q;
  assign bus.rsp_data  = s2_data_q;
  assign bus.rsp_mode  = s2_mode_q;
  assign bus.rsp_id    = s2_id_q;
  assign done_cnt      = cnt_q;
  assign dbg_ptr       = ptr_q;

endmodule
